cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
- Moore-style sequencer that sits directly upstream of the CPU execution unit.
- Fetches instructions and decodes the IR exported by the execution unit. Drives every execution-unit control strobe (reg_w_en, s_sel, adr_sel, pc_ld, pc_inc, ir_ld, alu_op) plus memory strobes.
- Handles a ready/wait memory handshake with timeout. Reports halt/error status and the current state for board LEDs.

Parameters:
- MEM_TIMEOUT, 15: consecutive not-ready cycles tolerated in any memory state before bus error; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- ir  input  16  instruction register contents from the execution unit; opcode = ir[15:9]
- C  input  1  carry flag from the execution unit
- N  input  1  negative flag from the execution unit
- Z  input  1  zero flag from the execution unit
- mem_rdy  input  1  memory completes the current read/write this cycle
- reg_w_en  output  1  register file write
- s_sel  output  1  0 = S operand from register file, 1 = memory data in
- adr_sel  output  1  0 = address from PC, 1 = address from R register
- pc_ld  output  1  PC loads ALU output
- pc_inc  output  1  PC increments
- ir_ld  output  1  IR loads memory data in
- alu_op  output  4  ALU operation; 4'h0 = pass R, 4'h1 = pass S
- mem_r_en  output  1  memory read request
- mem_w_en  output  1  memory write request
- halted  output  1  HALT state reached
- err  output  2  00 none, 01 illegal opcode, 10 bus timeout
- state  output  4  current state code

Behaviour:
- States and codes: RESET=0, FETCH=1, DECODE=2, ALU=3, LD=4, ST=5, LDI=6, JMP=7, BRT=8, BRN=9, HALT=10, ERR=11.
- Reset: reset high at a clock edge forces state=RESET, err=00, wait counter=0. Reset wins over everything, including mid-wait and HALT/ERR.
- RESET state: all strobes 0, alu_op=0, halted=0. Next state is FETCH unconditionally.
- Outputs are decoded from the state register. ir_ld, pc_inc, reg_w_en and pc_ld are additionally gated by mem_rdy where noted below.
- Strobes not listed for a state are 0.
- FETCH: adr_sel=0, mem_r_en=1, ir_ld=mem_rdy, pc_inc=mem_rdy. Goes to DECODE on mem_rdy.
- DECODE: no strobes. Samples C/N/Z. Next state by opcode:
  - 7'b111_xxxx -> ALU
  - 7'h60 LD -> LD
  - 7'h61 ST -> ST
  - 7'h62 LDI -> LDI
  - 7'h63 JMP -> JMP
  - 7'h64 BRZ, 7'h65 BRN, 7'h66 BRC -> BRT if the respective Z/N/C flag is 1, else BRN
  - 7'h67 JMPI -> BRT
  - 7'h68 HALT -> HALT
  - 7'h00 NOP -> FETCH
  - any other opcode -> ERR with err=01
- ALU (1 cycle): alu_op=ir[12:9], s_sel=0, reg_w_en=1. Next FETCH.
- LD: adr_sel=1, mem_r_en=1, s_sel=1, alu_op=1, reg_w_en=mem_rdy. Next FETCH on mem_rdy.
- ST: adr_sel=1, mem_w_en=1, alu_op=1. Holds until mem_rdy, then FETCH.
- LDI: adr_sel=0, mem_r_en=1, s_sel=1, alu_op=1, reg_w_en=mem_rdy, pc_inc=mem_rdy. Next FETCH on mem_rdy.
- JMP (1 cycle): alu_op=0, pc_ld=1. Next FETCH.
- BRT: adr_sel=0, mem_r_en=1, s_sel=1, alu_op=1, pc_ld=mem_rdy. Next FETCH on mem_rdy.
- BRN (1 cycle): pc_inc=1, which skips the target word. No memory access. Next FETCH.
- HALT: all strobes 0, halted=1. Stays until reset.
- ERR: all strobes 0. err holds its value. Stays until reset.
- Wait counter (8 bit):
  - Cleared on entry to each memory state (FETCH, LD, ST, LDI, BRT).
  - Increments each cycle in which mem_rdy=0.
  - If mem_rdy=0 and the counter equals MEM_TIMEOUT-1, next state is ERR with err=10.
  - A mem_rdy=1 on the final allowed cycle still completes normally.
- Invariants, every cycle:
  - pc_ld and pc_inc never both 1.
  - mem_r_en and mem_w_en never both 1.
  - reg_w_en never 1 in FETCH/DECODE.
  - Exactly one state active.
- Memory strobes stay asserted (level, not pulse) for the whole wait.

Test Plan:
- Reset, then mem_rdy=1 permanently, ir=16'hE200 (ALU op 1, W=0) -> states 0,1,2,3,1; ir_ld and pc_inc high only in the FETCH cycle; reg_w_en=1, alu_op=4'h1 in the ALU cycle.
- ir=16'hC000 (LD), mem_rdy low 3 cycles in LD -> adr_sel=1, mem_r_en=1 for 4 cycles; reg_w_en=1 only on the 4th; then FETCH.
- ir=16'hC800 (BRZ) with Z=1, then with Z=0 -> taken: BRT, pc_ld=1 with s_sel=1, alu_op=1. Not taken: BRN, single pc_inc, no mem_r_en.
- mem_rdy held 0 in FETCH, MEM_TIMEOUT=15 -> ERR entered after exactly 15 FETCH cycles, err=10. Strobes 0 afterward until reset.
- ir=16'h0200 (opcode 7'h01) -> ERR, err=01. ir=16'hD000 (HALT) -> halted=1, state=10, held 20 cycles. Reset asserted -> state=0 next edge, halted=0, err=00.
- Reset asserted mid-LD wait -> next edge state=0, reg_w_en/mem_r_en=0. Release reset -> normal FETCH resumes with a fresh wait counter.

Source files
------------

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: Moore sequencer driving the execution-unit control strobes,
// the memory read/write strobes with a ready/wait timeout, and halt/error status.
module cpu_control_unit #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] ir,
   input  logic        C,
   input  logic        N,
   input  logic        Z,
   input  logic        mem_rdy,
   output logic        reg_w_en,
   output logic        s_sel,
   output logic        adr_sel,
   output logic        pc_ld,
   output logic        pc_inc,
   output logic        ir_ld,
   output logic [3:0]  alu_op,
   output logic        mem_r_en,
   output logic        mem_w_en,
   output logic        halted,
   output logic [1:0]  err,
   output logic [3:0]  state
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   typedef enum logic [3:0] {
      S_RESET  = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_ALU    = 4'd3,
      S_LD     = 4'd4,
      S_ST     = 4'd5,
      S_LDI    = 4'd6,
      S_JMP    = 4'd7,
      S_BRT    = 4'd8,
      S_BRN    = 4'd9,
      S_HALT   = 4'd10,
      S_ERR    = 4'd11
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       err_q, err_d;
   logic [CNT_W-1:0] wait_q, wait_d;
   logic [6:0]       opcode;
   logic             is_mem;

   assign opcode = ir[15:9];

   // Low IR bits are operand fields consumed only by the execution unit.
   logic unused_ir;
   assign unused_ir = ^ir[8:0];

   // Next state, error code and memory wait counter.
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      wait_d  = wait_q;
      is_mem  = 1'b0;

      case (state_q)
         S_RESET: state_d = S_FETCH;
         S_FETCH: begin
            is_mem = 1'b1;
            if (mem_rdy) state_d = S_DECODE;
         end
         S_LD, S_ST, S_LDI, S_BRT: begin
            is_mem = 1'b1;
            if (mem_rdy) state_d = S_FETCH;
         end
         S_DECODE: begin
            casez (opcode)
               7'b111_????: state_d = S_ALU;
               7'h60:       state_d = S_LD;
               7'h61:       state_d = S_ST;
               7'h62:       state_d = S_LDI;
               7'h63:       state_d = S_JMP;
               7'h64:       state_d = Z ? S_BRT : S_BRN;
               7'h65:       state_d = N ? S_BRT : S_BRN;
               7'h66:       state_d = C ? S_BRT : S_BRN;
               7'h67:       state_d = S_BRT;
               7'h68:       state_d = S_HALT;
               7'h00:       state_d = S_FETCH;
               default: begin
                  state_d = S_ERR;
                  err_d   = ERR_ILLEGAL;
               end
            endcase
         end
         S_ALU, S_JMP, S_BRN: state_d = S_FETCH;
         S_HALT, S_ERR:       state_d = state_q;
         default:             state_d = S_ERR;
      endcase

      // A ready on the last allowed cycle still completes; only a further stall times out.
      if (is_mem && !mem_rdy && (wait_q == LAST_WAIT)) begin
         state_d = S_ERR;
         err_d   = ERR_TIMEOUT;
      end

      // Counter restarts on every state change so each memory state gets a fresh budget.
      if (state_d != state_q) begin
         wait_d = '0;
      end else if (is_mem && !mem_rdy) begin
         wait_d = wait_q + CNT_W'(1);
      end
   end

   // State, error and wait counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_RESET;
         err_q   <= ERR_NONE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         wait_q  <= wait_d;
      end
   end

   // Control strobes decoded from the state register, completion strobes gated by mem_rdy.
   always_comb begin
      reg_w_en = 1'b0;
      s_sel    = 1'b0;
      adr_sel  = 1'b0;
      pc_ld    = 1'b0;
      pc_inc   = 1'b0;
      ir_ld    = 1'b0;
      alu_op   = 4'h0;
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      halted   = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_r_en = 1'b1;
            ir_ld    = mem_rdy;
            pc_inc   = mem_rdy;
         end
         S_ALU: begin
            alu_op   = ir[12:9];
            reg_w_en = 1'b1;
         end
         S_LD: begin
            adr_sel  = 1'b1;
            mem_r_en = 1'b1;
            s_sel    = 1'b1;
            alu_op   = 4'h1;
            reg_w_en = mem_rdy;
         end
         S_ST: begin
            adr_sel  = 1'b1;
            mem_w_en = 1'b1;
            alu_op   = 4'h1;
         end
         S_LDI: begin
            mem_r_en = 1'b1;
            s_sel    = 1'b1;
            alu_op   = 4'h1;
            reg_w_en = mem_rdy;
            pc_inc   = mem_rdy;
         end
         S_JMP: begin
            pc_ld = 1'b1;
         end
         S_BRT: begin
            mem_r_en = 1'b1;
            s_sel    = 1'b1;
            alu_op   = 4'h1;
            pc_ld    = mem_rdy;
         end
         S_BRN: begin
            pc_inc = 1'b1;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign err   = err_q;
   assign state = state_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: an instruction-level model expands each instruction
// and its memory-wait plan into expected per-cycle outputs, then replays them.
module tb_cpu_control_unit;

   localparam int unsigned TO = 15;

   localparam logic [3:0] S_RESET = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_ALU = 4'd3,
                          S_LD = 4'd4, S_ST = 4'd5, S_LDI = 4'd6, S_JMP = 4'd7,
                          S_BRT = 4'd8, S_BRN = 4'd9, S_HALT = 4'd10, S_ERR = 4'd11;

   logic        clk, reset, C, N, Z, mem_rdy;
   logic [15:0] ir;
   logic        reg_w_en, s_sel, adr_sel, pc_ld, pc_inc, ir_ld, mem_r_en, mem_w_en, halted;
   logic [3:0]  alu_op, state;
   logic [1:0]  err;

   cpu_control_unit #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .ir(ir), .C(C), .N(N), .Z(Z), .mem_rdy(mem_rdy),
      .reg_w_en(reg_w_en), .s_sel(s_sel), .adr_sel(adr_sel), .pc_ld(pc_ld),
      .pc_inc(pc_inc), .ir_ld(ir_ld), .alu_op(alu_op), .mem_r_en(mem_r_en),
      .mem_w_en(mem_w_en), .halted(halted), .err(err), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic [15:0] ir;
      logic        c, n, z;
      logic [18:0] v;
   } cyc_t;

   cyc_t        q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] cur_ir = '0;
   logic        cur_c = 1'b0, cur_n = 1'b0, cur_z = 1'b0;
   logic [1:0]  m_err = 2'b00;

   // Single comparison point: counts and reports.
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [18:0] mk(input logic [3:0] st, input logic rwe, ssel, asel,
                                      pcld, pcinc, irld, input logic [3:0] aop,
                                      input logic mre, mwe, hlt, input logic [1:0] er);
      return {rwe, ssel, asel, pcld, pcinc, irld, aop, mre, mwe, hlt, er, st};
   endfunction

   function automatic logic [18:0] idle(input logic [3:0] st);
      return mk(st, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, (st == S_HALT), (st == S_ERR) ? m_err : 2'b00);
   endfunction

   task automatic push(input logic rdy, input logic [18:0] v);
      cyc_t e;
      e.rst = 1'b0; e.rdy = rdy; e.ir = cur_ir;
      e.c = cur_c; e.n = cur_n; e.z = cur_z; e.v = v;
      q.push_back(e);
   endtask

   // Reset asserted during the last queued cycle; the following cycle shows RESET.
   task automatic do_reset();
      q[q.size()-1].rst = 1'b1;
      m_err = 2'b00;
      push(1'($urandom), idle(S_RESET));
   endtask

   task automatic term(input logic [3:0] st, input int n);
      for (int i = 0; i < n; i++) push(1'($urandom), idle(st));
      do_reset();
   endtask

   // A memory state stalled for wn cycles; a stall reaching TO cycles is a timeout.
   task automatic mem_phase(input logic [3:0] st, input int wn, input logic asel, ssel,
                            input logic [3:0] aop, input logic mre, mwe,
                            g_rwe, g_pcld, g_pcinc, g_irld, output bit to);
      int nw;
      nw = (wn < int'(TO)) ? wn : int'(TO);
      for (int i = 0; i < nw; i++)
         push(1'b0, mk(st, 0, ssel, asel, 0, 0, 0, aop, mre, mwe, 0, 2'b00));
      to = (wn >= int'(TO));
      if (!to)
         push(1'b1, mk(st, g_rwe, ssel, asel, g_pcld, g_pcinc, g_irld, aop, mre, mwe, 0, 2'b00));
   endtask

   task automatic run_instr(input logic [15:0] irv, input logic c, n, z, input int wf, we);
      bit         to;
      logic [6:0] op;
      logic       taken;
      cur_ir = irv; cur_c = c; cur_n = n; cur_z = z;
      op = irv[15:9];
      to = 1'b0;
      mem_phase(S_FETCH, wf, 0, 0, 4'h0, 1, 0, 0, 0, 1, 1, to);
      if (to) begin
         m_err = 2'b10;
         term(S_ERR, 3);
         return;
      end
      push(1'($urandom), idle(S_DECODE));
      if (op[6:4] == 3'b111) begin
         push(1'($urandom), mk(S_ALU, 1, 0, 0, 0, 0, 0, irv[12:9], 0, 0, 0, 2'b00));
      end else begin
         case (op)
            7'h60: mem_phase(S_LD,  we, 1, 1, 4'h1, 1, 0, 1, 0, 0, 0, to);
            7'h61: mem_phase(S_ST,  we, 1, 0, 4'h1, 0, 1, 0, 0, 0, 0, to);
            7'h62: mem_phase(S_LDI, we, 0, 1, 4'h1, 1, 0, 1, 0, 1, 0, to);
            7'h63: push(1'($urandom), mk(S_JMP, 0, 0, 0, 1, 0, 0, 4'h0, 0, 0, 0, 2'b00));
            7'h64, 7'h65, 7'h66: begin
               taken = (op == 7'h64) ? z : (op == 7'h65) ? n : c;
               if (taken) mem_phase(S_BRT, we, 0, 1, 4'h1, 1, 0, 0, 1, 0, 0, to);
               else push(1'($urandom), mk(S_BRN, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 2'b00));
            end
            7'h67: mem_phase(S_BRT, we, 0, 1, 4'h1, 1, 0, 0, 1, 0, 0, to);
            7'h68: term(S_HALT, 20);
            7'h00: begin
            end
            default: begin
               m_err = 2'b01;
               term(S_ERR, 3);
            end
         endcase
      end
      if (to) begin
         m_err = 2'b10;
         term(S_ERR, 3);
      end
   endtask

   function automatic bit legal(input logic [6:0] op);
      return (op[6:4] == 3'b111) || (op >= 7'h60 && op <= 7'h68) || (op == 7'h00);
   endfunction

   function automatic logic [6:0] rand_op();
      logic [6:0] op;
      int r;
      r = int'($urandom_range(0, 11));
      case (r)
         0, 1: op = {3'b111, 4'($urandom)};
         2: op = 7'h60;  3: op = 7'h61;  4: op = 7'h62;  5: op = 7'h63;
         6: op = 7'h64;  7: op = 7'h65;  8: op = 7'h66;  9: op = 7'h67;
         10: op = 7'h00;
         default: begin
            if ($urandom_range(0, 3) == 0) op = 7'h68;
            else begin
               op = 7'($urandom);
               while (legal(op)) op = 7'($urandom);
            end
         end
      endcase
      return op;
   endfunction

   function automatic int rand_wait();
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 82) return int'($urandom_range(0, 3));
      if (r < 92) return int'(TO) - 1;
      if (r < 97) return int'($urandom_range(4, TO - 2));
      return int'(TO);
   endfunction

   initial begin
      reset = 1'b1; mem_rdy = 1'b0; ir = '0; C = 1'b0; N = 1'b0; Z = 1'b0;

      // Directed sequence.
      push(1'b1, idle(S_RESET));
      run_instr(16'hE200, 0, 0, 0, 0, 0);
      run_instr(16'hC000, 0, 0, 0, 0, 3);
      run_instr(16'hC800, 0, 0, 1, 0, 0);
      run_instr(16'hC800, 1, 1, 0, 0, 0);
      run_instr(16'hC200, 0, 0, 0, 2, 5);
      run_instr(16'hC400, 0, 0, 0, 0, int'(TO) - 1);
      run_instr(16'h0000, 0, 0, 0, 1, 0);
      run_instr(16'hC600, 0, 0, 0, 0, 0);
      run_instr(16'hE200, 0, 0, 0, int'(TO), 0);
      run_instr(16'h0200, 0, 0, 0, 0, 0);
      run_instr(16'hD000, 0, 0, 0, 0, 0);
      run_instr(16'hC000, 0, 0, 0, 0, 0);
      run_instr(16'hC200, 0, 0, 0, 0, int'(TO));
      // Reset in the middle of an LD stall, then a fetch using nearly the whole budget.
      cur_ir = 16'hC000;
      begin
         bit to;
         mem_phase(S_FETCH, 0, 0, 0, 4'h0, 1, 0, 0, 0, 1, 1, to);
      end
      push(1'b1, idle(S_DECODE));
      for (int i = 0; i < 3; i++)
         push(1'b0, mk(S_LD, 0, 1, 1, 0, 0, 0, 4'h1, 1, 0, 0, 2'b00));
      do_reset();
      run_instr(16'hE400, 0, 0, 0, int'(TO) - 1, 0);

      // Randomized instruction stream.
      for (int k = 0; k < 300; k++)
         run_instr({rand_op(), 9'($urandom)}, 1'($urandom), 1'($urandom), 1'($urandom),
                   rand_wait(), rand_wait());

      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < q.size(); i++) begin
         reset = q[i].rst; mem_rdy = q[i].rdy; ir = q[i].ir;
         C = q[i].c; N = q[i].n; Z = q[i].z;
         @(negedge clk);
         check($sformatf("cyc%0d", i),
               32'({reg_w_en, s_sel, adr_sel, pc_ld, pc_inc, ir_ld, alu_op,
                    mem_r_en, mem_w_en, halted, err, state}), 32'(q[i].v));
         check("inv_pc", 32'(pc_ld & pc_inc), 32'd0);
         check("inv_mem", 32'(mem_r_en & mem_w_en), 32'd0);
         check("inv_state", 32'(state > 4'd11), 32'd0);
         @(posedge clk);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
